// File: rtl/dtree_pkg.sv
// dtree_pkg: node word field layout, FSM states and a leaf-word encoder for the sequential tree evaluator.
package dtree_pkg;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + $clog2(n_feat) + $clog2(feat_w) + feat_w + 2 * $clog2(n_nodes);
  endfunction
  function automatic int left_lo(input int n_nodes);
    return $clog2(n_nodes);
  endfunction
  function automatic int thr_lo(input int n_nodes);
    return 2 * $clog2(n_nodes);
  endfunction
  function automatic int keep_lo(input int feat_w, input int n_nodes);
    return thr_lo(n_nodes) + feat_w;
  endfunction
  function automatic int fidx_lo(input int feat_w, input int n_nodes);
    return keep_lo(feat_w, n_nodes) + $clog2(feat_w);
  endfunction
  // Leaf word: leaf bit set, class in the low bits of the threshold field.
  function automatic logic [63:0] leaf_word(input int n_feat, input int feat_w, input int n_nodes, input int cls);
    return (64'd1 << (node_w(n_feat, feat_w, n_nodes) - 1)) | (64'(cls) << thr_lo(n_nodes));
  endfunction
endpackage

// File: rtl/dtree_node_cmp.sv
// dtree_node_cmp: decodes one node word and picks the child from the latched feature vector.
module dtree_node_cmp
  import dtree_pkg::*;
#(
  parameter int N_FEAT = 18,
  parameter int FEAT_W = 8,
  parameter int N_NODES = 64,
  parameter int CLASS_W = 2,
  localparam int FIDX_W = $clog2(N_FEAT),
  localparam int KEEP_W = $clog2(FEAT_W),
  localparam int NIDX_W = $clog2(N_NODES),
  localparam int NODE_W = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic [N_FEAT*FEAT_W-1:0] x,
  input  logic [NODE_W-1:0]        node,
  output logic [NIDX_W-1:0]        nxt,
  output logic                     is_leaf,
  output logic [CLASS_W-1:0]       cls,
  output logic                     fault
);
  localparam int FL = fidx_lo(FEAT_W, N_NODES);
  localparam int KL = keep_lo(FEAT_W, N_NODES);
  localparam int TL = thr_lo(N_NODES);
  localparam int LL = left_lo(N_NODES);
  localparam logic [KEEP_W:0] FW = (KEEP_W + 1)'(FEAT_W);
  logic [FIDX_W-1:0] fidx;
  logic [KEEP_W:0] k;
  logic [FEAT_W-1:0] thr, feat, mask;
  logic go_left;
  assign is_leaf = node[NODE_W-1];
  assign fidx = node[FL +: FIDX_W];
  assign k = {1'b0, node[KL +: KEEP_W]} + (KEEP_W + 1)'(1);
  assign thr = node[TL +: FEAT_W];
  assign cls = thr[CLASS_W-1:0];
  always_comb begin
    feat = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (fidx == FIDX_W'(i)) feat = x[i*FEAT_W +: FEAT_W];
  end
  // Compare only the top k feature bits against the low k threshold bits.
  assign mask = ~({FEAT_W{1'b1}} << k);
  assign go_left = (feat >> (FW - k)) <= (thr & mask);
  assign nxt = go_left ? node[LL +: NIDX_W] : node[0 +: NIDX_W];
  assign fault = !is_leaf && (({1'b0, fidx} >= (FIDX_W + 1)'(N_FEAT)) ||
                              ({1'b0, nxt} >= (NIDX_W + 1)'(N_NODES)));
endmodule

// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: programmable decision-tree classifier walking a writable node table one node per clock.
module dtree_seq_eval
  import dtree_pkg::*;
#(
  parameter int N_FEAT = 18,
  parameter int FEAT_W = 8,
  parameter int N_NODES = 64,
  parameter int CLASS_W = 2,
  parameter int MAX_DEPTH = 16,
  localparam int FIDX_W = $clog2(N_FEAT),
  localparam int KEEP_W = $clog2(FEAT_W),
  localparam int NIDX_W = $clog2(N_NODES),
  localparam int NODE_W = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_FEAT*FEAT_W-1:0] in_x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     cfg_we,
  input  logic [NIDX_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_busy
);
  localparam int DEP_W = $clog2(MAX_DEPTH + 1);
  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};
  state_t state, nxt_state;
  logic [NODE_W-1:0] mem [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] xq;
  logic [NIDX_W-1:0] ptr, child;
  logic [DEP_W-1:0] depth;
  logic [CLASS_W-1:0] cls;
  logic rdy, leaf, fault, stop, acc;
  dtree_node_cmp #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES), .CLASS_W(CLASS_W)) u_cmp (
    .x(xq), .node(mem[ptr]), .nxt(child), .is_leaf(leaf), .cls(cls), .fault(fault)
  );
  // rdy keeps in_ready low until the first clock after reset release.
  assign in_ready = (state == IDLE) && rdy;
  assign cfg_busy = state != IDLE;
  assign out_valid = state == DONE;
  assign acc = in_valid && in_ready;
  assign stop = leaf || fault || (depth == DEP_W'(MAX_DEPTH));
  always_comb begin
    nxt_state = (state == IDLE && acc) ? WALK :
                (state == WALK && stop) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= 1'b0;
      xq <= '0;
      ptr <= '0;
      depth <= '0;
      out_class <= '0;
      out_err <= 1'b0;
      for (int i = 0; i < N_NODES; i++) mem[i] <= LEAF0;
    end else begin
      rdy <= 1'b1;
      if (acc) begin
        xq <= in_x;
        ptr <= '0;
        depth <= '0;
      end
      if (state == WALK) begin
        if (stop) begin
          out_class <= leaf ? cls : '0;
          out_err <= !leaf;
        end else begin
          ptr <= child;
          depth <= depth + 1'b1;
        end
      end
      if (cfg_we && !cfg_busy && ({1'b0, cfg_addr} < (NIDX_W + 1)'(N_NODES))) mem[cfg_addr] <= cfg_data;
    end
  end
endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: directed bench with a behavioural tree-walk model and a per-cycle output checker.
module tb_dtree_seq_eval;
  import dtree_pkg::*;
  localparam int NF = 18, FW = 8, NN = 64, CW = 2, MD = 16, NW = 29;
  logic clk = 1'b0, rst = 1'b1;
  logic [NF*FW-1:0] in_x = '0;
  logic in_valid = 1'b0, in_ready, out_err, out_valid, out_ready = 1'b1, cfg_we = 1'b0, cfg_busy;
  logic [CW-1:0] out_class;
  logic [5:0] cfg_addr = '0;
  logic [NW-1:0] cfg_data = '0;
  dtree_seq_eval #(.N_FEAT(NF), .FEAT_W(FW), .N_NODES(NN), .CLASS_W(CW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
    .out_class(out_class), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  bit m_leaf [NN];
  int m_fidx [NN], m_keep [NN], m_thr [NN], m_l [NN], m_r [NN];
  bit pend = 0, rdy_exp = 0, e_err = 0;
  int cyc = 0, due = 0, e_cls = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < NN; i++) begin
      m_leaf[i] = 1; m_thr[i] = 0; m_fidx[i] = 0; m_keep[i] = 0; m_l[i] = 0; m_r[i] = 0;
    end
  endfunction
  // Walk the table from the root; lat counts clocks from acceptance edge to out_valid.
  function automatic void model(input logic [NF*FW-1:0] x, output int cls, output bit err, output int lat);
    int p = 0, d = 0, k, f, c;
    cls = 0; err = 1; lat = 0;
    for (int s = 0; s <= MD + 1; s++) begin
      if (m_leaf[p]) begin cls = m_thr[p] % (1 << CW); err = 0; lat = d + 2; return; end
      lat = d + 2;
      if (m_fidx[p] >= NF || d == MD) return;
      k = m_keep[p] + 1;
      f = int'(x[m_fidx[p]*FW +: FW]);
      c = ((f >> (FW - k)) <= (m_thr[p] % (1 << k))) ? m_l[p] : m_r[p];
      if (c >= NN) return;
      p = c; d++;
    end
  endfunction
  function automatic logic [NF*FW-1:0] mkx(input int f7);
    logic [NF*FW-1:0] v;
    for (int i = 0; i < NF; i++) v[i*FW +: FW] = 8'($urandom);
    v[7*FW +: FW] = 8'(f7);
    return v;
  endfunction
  always @(posedge clk or posedge rst) begin
    bit acc, hs, e;
    int c, l;
    if (rst) begin
      pend = 0; rdy_exp = 0; model_reset();
    end else begin
      acc = in_valid && rdy_exp && !pend;
      hs = pend && cyc >= due && out_ready;
      cyc++;
      if (hs) pend = 0;
      if (acc) begin model(in_x, c, e, l); pend = 1; e_cls = c; e_err = e; due = cyc + l - 1; end
      rdy_exp = 1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
      chk("rst_out_class", out_class, 0); chk("rst_out_err", out_err, 0); chk("rst_cfg_busy", cfg_busy, 0);
    end else begin
      chk("in_ready", in_ready, rdy_exp && !pend);
      chk("cfg_busy", cfg_busy, pend);
      if (pend && cyc >= due) begin
        chk("out_valid", out_valid, 1); chk("out_class", out_class, e_cls); chk("out_err", out_err, e_err);
      end else chk("out_valid_low", out_valid, 0);
    end
  end
  task automatic wr_leaf(input int a, input int c);
    logic [63:0] w;
    w = leaf_word(NF, FW, NN, c);
    @(negedge clk);
    cfg_we = 1; cfg_addr = 6'(a); cfg_data = w[NW-1:0];
    m_leaf[a] = 1; m_thr[a] = c;
    @(negedge clk);
    cfg_we = 0;
  endtask
  task automatic wr_int(input int a, input int f, input int k, input int t, input int l, input int r);
    @(negedge clk);
    cfg_we = 1; cfg_addr = 6'(a); cfg_data = {1'b0, 5'(f), 3'(k), 8'(t), 6'(l), 6'(r)};
    m_leaf[a] = 0; m_fidx[a] = f; m_keep[a] = k; m_thr[a] = t; m_l[a] = l; m_r[a] = r;
    @(negedge clk);
    cfg_we = 0;
  endtask
  // hold>0 stalls out_ready and attempts a node-1 write during DONE; swr writes node 2 = leaf 3 in the accept cycle.
  task automatic run_vec(input logic [NF*FW-1:0] x, input int ecls, input bit eerr, input int elat,
                         input int hold, input bit swr);
    int mc, ml, lat, n;
    bit me;
    logic [63:0] w3;
    w3 = leaf_word(NF, FW, NN, 3);
    @(negedge clk);
    in_x = x; in_valid = 1; out_ready = (hold == 0);
    if (swr) begin cfg_we = 1; cfg_addr = 6'd2; cfg_data = w3[NW-1:0]; m_leaf[2] = 1; m_thr[2] = 3; end
    model(x, mc, me, ml);
    chk("model_cls", mc, ecls); chk("model_err", me, eerr); chk("model_lat", ml, elat);
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    chk("accept", in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0; cfg_we = 0; in_x = mkx(8'hA5);
    while (!out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    chk("latency", lat, elat); chk("dut_cls", out_class, ecls); chk("dut_err", out_err, eerr);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin cfg_we = 1; cfg_addr = 6'd1; cfg_data = w3[NW-1:0]; end
        else cfg_we = 0;
        @(negedge clk);
      end
      cfg_we = 0;
      chk("hold_valid", out_valid, 1); chk("hold_cls", out_class, ecls); chk("hold_in_ready", in_ready, 0);
      out_ready = 1;
    end
    @(posedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    run_vec(mkx(0), 0, 0, 2, 0, 0);
    wr_int(0, 7, 1, 3, 1, 2); wr_leaf(1, 1); wr_leaf(2, 2);
    run_vec(mkx('hC0), 1, 0, 3, 0, 0);
    wr_int(0, 7, 2, 2, 1, 2);
    run_vec(mkx('hE0), 2, 0, 3, 0, 0);
    run_vec(mkx('h5F), 1, 0, 3, 0, 0);
    run_vec(mkx('h60), 2, 0, 3, 0, 0);
    run_vec(mkx('hE0), 2, 0, 3, 5, 0);
    run_vec(mkx('h40), 1, 0, 3, 0, 0);
    run_vec(mkx('hE0), 3, 0, 3, 0, 1);
    wr_int(0, 20, 0, 0, 1, 2);
    run_vec(mkx(0), 0, 1, 2, 0, 0);
    wr_int(0, 7, 7, 255, 3, 3); wr_int(3, 20, 0, 0, 1, 2);
    run_vec(mkx(0), 0, 1, 3, 0, 0);
    for (int i = 0; i < 16; i++) wr_int(i, 0, 7, 0, (i + 1) % 16, (i + 1) % 16);
    run_vec(mkx(0), 0, 1, 18, 0, 0);
    @(negedge clk);
    in_x = mkx(0); in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_out_valid", out_valid, 0); chk("async_in_ready", in_ready, 0);
    chk("async_cfg_busy", cfg_busy, 0); chk("async_out_err", out_err, 0); chk("async_out_class", out_class, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    repeat (25) @(negedge clk);
    run_vec(mkx('hC0), 0, 0, 2, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
